// File: rtl/serial_mag_cmp_pkg.sv
// Shared constants, FSM state type and sizing helpers for the serial
// magnitude comparator.
package serial_mag_cmp_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nibs(input int width);
      return width / NIB_W;
   endfunction

   // Index counter width; a single-nibble operand still gets one bit.
   function automatic int idx_w(input int width);
      return (nibs(width) > 1) ? $clog2(nibs(width)) : 1;
   endfunction

endpackage

// File: rtl/serial_mag_cmp_nibble_cmp.sv
// Combinational 4-bit unsigned compare; exactly one of g/e/l is high.
import serial_mag_cmp_pkg::*;

module nibble_cmp (
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   output logic             g,
   output logic             e,
   output logic             l
);

   assign g = (a > b);
   assign e = (a == b);
   assign l = (a < b);

endmodule

// File: rtl/serial_mag_cmp.sv
// Multi-cycle unsigned magnitude comparator: scans one nibble per cycle,
// MSB first, through a single nibble comparator, with in/out handshakes.
import serial_mag_cmp_pkg::*;

module serial_mag_cmp #(
   parameter int WIDTH      = 16,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int NIB   = nibs(WIDTH);
   localparam int IDX_W = idx_w(WIDTH);

   generate
      if ((WIDTH % NIB_W != 0) || (WIDTH < NIB_W)) begin : g_bad_width
         $fatal(1, "serial_mag_cmp: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sa, sb;
   logic [IDX_W-1:0]   idx;
   logic               sticky_gt, sticky_lt;
   logic               gt_r, eq_r, lt_r;
   logic               n_g, n_e, n_l;
   logic               decide;
   logic               res_gt, res_lt;

   nibble_cmp u_nibble_cmp (
      .a (sa[WIDTH-1 -: NIB_W]),
      .b (sb[WIDTH-1 -: NIB_W]),
      .g (n_g),
      .e (n_e),
      .l (n_l)
   );

   assign decide = (EARLY_EXIT && !n_e) || (idx == '0);

   // An earlier captured difference outranks the current nibble; in early-exit
   // mode the sticky bits are never set before the deciding nibble.
   assign res_gt = (sticky_gt || sticky_lt) ? sticky_gt : n_g;
   assign res_lt = (sticky_gt || sticky_lt) ? sticky_lt : n_l;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign gt        = gt_r;
   assign eq        = eq_r;
   assign lt        = lt_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)       state_nxt = SCAN;
         SCAN:    if (decide)         state_nxt = DONE;
         DONE:    if (out_ready)      state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa        <= '0;
         sb        <= '0;
         idx       <= '0;
         sticky_gt <= 1'b0;
         sticky_lt <= 1'b0;
         gt_r      <= 1'b0;
         eq_r      <= 1'b0;
         lt_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sa        <= a;
                  sb        <= b;
                  idx       <= IDX_W'(NIB - 1);
                  sticky_gt <= 1'b0;
                  sticky_lt <= 1'b0;
               end
            end
            SCAN: begin
               if (decide) begin
                  gt_r <= res_gt;
                  lt_r <= res_lt;
                  eq_r <= !res_gt && !res_lt;
               end else begin
                  sa  <= sa << NIB_W;
                  sb  <= sb << NIB_W;
                  idx <= idx - 1'b1;
                  if (!n_e && !sticky_gt && !sticky_lt) begin
                     sticky_gt <= n_g;
                     sticky_lt <= n_l;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  gt_r <= 1'b0;
                  eq_r <= 1'b0;
                  lt_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed bench for serial_mag_cmp: an early-exit and a full-scan instance.
module tb_serial_mag_cmp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        in_valid0 = 1'b0, out_ready0 = 1'b1;
   logic [15:0] a0 = '0, b0 = '0;
   logic        in_ready0, out_valid0, gt0, eq0, lt0;

   logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
   logic [15:0] a1 = '0, b1 = '0;
   logic        in_ready1, out_valid1, gt1, eq1, lt1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_mag_cmp #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_ee (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
      .gt(gt0), .eq(eq0), .lt(lt0)
   );

   serial_mag_cmp #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_fs (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
      .gt(gt1), .eq(eq1), .lt(lt1)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Flags packed as {gt,eq,lt} for compact comparisons.
   function automatic int flags(input bit fs);
      return fs ? int'({gt1, eq1, lt1}) : int'({gt0, eq0, lt0});
   endfunction

   // Launch one transaction, measure latency, check result and the return to IDLE.
   task automatic run_txn(input string tag, input bit fs, input logic [15:0] av,
                          input logic [15:0] bv, input int exp_k, input int exp_f);
      int k;
      k = 0;
      if (fs) begin a1 = av; b1 = bv; in_valid1 = 1'b1; end
      else    begin a0 = av; b0 = bv; in_valid0 = 1'b1; end
      @(posedge clk); #1;
      // Operand changes after acceptance must be ignored.
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      a0 = ~av; b0 = 16'h0; a1 = ~av; b1 = 16'h0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if ((fs ? out_valid1 : out_valid0) === 1'b1) begin
            k = i;
            break;
         end
      end
      chk({tag, "_latency"}, k, exp_k);
      chk({tag, "_flags"}, flags(fs), exp_f);
      @(posedge clk); #1;
      chk({tag, "_in_ready_after"}, int'(fs ? in_ready1 : in_ready0), 1);
      chk({tag, "_cleared"}, int'({fs ? out_valid1 : out_valid0, 3'(flags(fs))}), 0);
   endtask

   initial begin
      bit seen;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ee", int'({in_ready0, out_valid0, gt0, eq0, lt0}), 'b10000);
      chk("reset_fs", int'({in_ready1, out_valid1, gt1, eq1, lt1}), 'b10000);
      rst = 1'b0;
      @(posedge clk); #1;

      run_txn("equal_ee",  1'b0, 16'h1234, 16'h1234, 4, 'b010);
      run_txn("msb_gt_ee", 1'b0, 16'h8000, 16'h7FFF, 1, 'b100);
      run_txn("lsb_lt_ee", 1'b0, 16'h1230, 16'h1231, 4, 'b001);
      run_txn("sticky_fs", 1'b1, 16'h8000, 16'h0FFF, 4, 'b100);
      run_txn("equal_fs",  1'b1, 16'h5A5A, 16'h5A5A, 4, 'b010);
      run_txn("lsb_lt_fs", 1'b1, 16'h1230, 16'h1231, 4, 'b001);

      // Backpressure: result holds while the consumer stalls.
      out_ready0 = 1'b0;
      a0 = 16'h00F0; b0 = 16'h00E0; in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_valid_at_3", int'({out_valid0, gt0, eq0, lt0}), 'b1100);
      seen = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (!(out_valid0 === 1'b1 && gt0 === 1'b1 && eq0 === 1'b0 &&
               lt0 === 1'b0 && in_ready0 === 1'b0)) seen = 1'b0;
      end
      chk("bp_hold", int'(seen), 1);
      out_ready0 = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", int'({out_valid0, gt0, eq0, lt0, in_ready0}), 'b00001);

      // Reset in the middle of a scan abandons the transaction.
      a0 = 16'h0001; b0 = 16'h0002; in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_scan", int'({in_ready0, out_valid0, gt0, eq0, lt0}), 'b10000);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid0 !== 1'b0) seen = 1'b1;
      end
      chk("rst_no_result", int'(seen), 0);
      run_txn("after_rst_ee", 1'b0, 16'h0002, 16'h0001, 4, 'b100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

- Multi-cycle magnitude comparator for two unsigned WIDTH-bit operands.
- Compares one 4-bit nibble per cycle, MSB nibble first, using a single nibble-comparator instance.
- Sits as the control and sequencing stage around that nibble comparator: it feeds operand nibbles in and consumes the greater/equal/less results.
- Has a valid/ready input handshake and a valid/ready output handshake, and reports exactly one of gt/eq/lt per transaction.

## Interface
- WIDTH, default 16: operand width. Must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- EARLY_EXIT, default 1:
  - 1: stop at the first unequal nibble.
  - 0: always scan all NIB nibbles (constant latency).
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands a/b are valid.
- in_ready  out  1  block accepts operands.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- gt  out  1  A > B.
- eq  out  1  A == B.
- lt  out  1  A < B.

## Operation
- FSM states:
  - IDLE → SCAN on in_valid & in_ready.
  - SCAN → DONE on a decision.
  - DONE → IDLE on out_valid & out_ready.
- in_ready = (state == IDLE), combinational from state. There is no acceptance in any other state.
- On accept:
  - Latch a and b into shift registers sa/sb.
  - Nibble index idx = NIB-1.
- SCAN, each cycle:
  - Compare sa[WIDTH-1 -: 4] vs sb[WIDTH-1 -: 4] in the nibble comparator.
  - Decision when (EARLY_EXIT & nibble unequal) | (idx == 0).
  - No decision: shift sa/sb left by 4 and decrement idx.
- Result latching, EARLY_EXIT=1: on a decision, latch the nibble's gt/eq/lt into the output regs.
- Result latching, EARLY_EXIT=0:
  - Keep a sticky "first difference" result: {gt,lt} is captured at the first unequal nibble and never overwritten.
  - At idx==0, output the sticky result, or eq if no difference was seen.
- out_valid = (state == DONE).
- gt/eq/lt are registered, one-hot while out_valid, and all 0 otherwise (cleared on DONE→IDLE).
- Outputs hold stable while out_valid & !out_ready.
- Reset:
  - state=IDLE, so in_ready=1.
  - out_valid=0, gt=eq=lt=0.
  - sa=sb=0, idx=0, sticky=0.
- Reset during SCAN or DONE abandons the transaction; no result is emitted.
- in_valid with a/b changing during SCAN/DONE is ignored; operands are already latched.

## Timing
- Accept at edge T0.
- Decision evaluated in SCAN cycle k (k = 1..NIB, one nibble per cycle after T0).
- out_valid rises at edge T0+k.
- Latency:
  - EARLY_EXIT=1: k = position of first unequal nibble from the MSB, or NIB if equal.
  - EARLY_EXIT=0: k = NIB always.
- Earliest next accept is the cycle after the out handshake, so minimum transaction period = k+2 cycles.
- Nibble comparator is purely combinational inside SCAN; no extra pipeline stage.
- WIDTH=4: NIB=1, so SCAN always lasts one cycle.

## Structure
- Package serial_mag_cmp_pkg holds:
  - NIB_W = 4.
  - State enum {IDLE, SCAN, DONE}.
  - Function nibs(width) = width/4, used for idx sizing, $clog2(NIB) with a minimum of 1 bit.
- One sub-module, nibble_cmp: combinational 4-bit compare producing g/e/l (one-hot).
  - Instantiated once, fed by the top nibbles of sa/sb.
- Elaboration-time check: WIDTH % 4 == 0 and WIDTH ≥ 4, else fatal.

## Test plan
All cases use WIDTH=16 unless noted.
- Equal, EARLY_EXIT=1: a=0x1234, b=0x1234, out_ready=1 → out_valid at T0+4 with eq=1, gt=lt=0; in_ready returns 1 at T0+5.
- MSB decision, EARLY_EXIT=1: a=0x8000, b=0x7FFF → out_valid at T0+1 with gt=1.
- LSB decision: a=0x1230, b=0x1231 → out_valid at T0+4 with lt=1.
- EARLY_EXIT=0: a=0x8000, b=0x0FFF → out_valid at T0+4 with gt=1; the sticky MSB difference is not overwritten by the later lt nibbles.
- Backpressure: a=0x00F0, b=0x00E0, out_ready=0 for 5 cycles → out_valid at T0+3 with gt=1, held stable with in_ready=0 throughout; clears the cycle after out_ready=1.
- Reset mid-SCAN: accept a=0x0001, b=0x0002, assert rst at T0+2 → out_valid=0 and gt/eq/lt=0 immediately; in_ready=1; no result is ever produced. A fresh transaction afterwards completes normally.
